// File: rtl/slip_dram_pkg.sv
`default_nettype none
// ============================================================================
// slip_dram_pkg
//   Shared types and constants for the DRAM access sequencer: the sequencer
//   state encoding, the default address width and the idle strobe level.
// Revision: 1.0  initial release
// ============================================================================
package slip_dram_pkg;

  // Default row/column address width.
  localparam int c_AW_DEFAULT = 9;

  // DRAM strobes are active-low; this is their released level.
  localparam logic c_STROBE_OFF = 1'b1;

  // Sequencer states: access path first, then the refresh path.
  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_ROW     = 4'd1,
    ST_COL     = 4'd2,
    ST_CAS1    = 4'd3,
    ST_CAS2    = 4'd4,
    ST_PRE     = 4'd5,
    ST_RF_CAS  = 4'd6,
    ST_RF_RAS  = 4'd7,
    ST_RF_HOLD = 4'd8
  } state_e;

endpackage
`default_nettype wire

// File: rtl/dram_seq_if.sv
`default_nettype none
// ============================================================================
// dram_seq_if
//   Request/strobe bundle between an access master and the DRAM sequencer.
// Revision: 1.0  initial release
// ============================================================================
interface dram_seq_if
  import slip_dram_pkg::*;
#(
  parameter int AW = c_AW_DEFAULT
);
  logic            REQ;     // access request, held until ACK
  logic            WR;      // 1 = write, 0 = read
  logic [2*AW-1:0] ADDR;    // {row, column}
  logic [AW-1:0]   MA;      // muxed DRAM address
  logic            MUXSEL;  // 0 = row on MA, 1 = column on MA
  logic            RASL;
  logic            CASL;
  logic            WEL;
  logic            ACK;     // one-cycle completion pulse
  logic            BUSY;

  modport master (
    output REQ, WR, ADDR,
    input  MA, MUXSEL, RASL, CASL, WEL, ACK, BUSY
  );

  modport slave (
    input  REQ, WR, ADDR,
    output MA, MUXSEL, RASL, CASL, WEL, ACK, BUSY
  );
endinterface
`default_nettype wire

// File: rtl/dram_reftmr.sv
`default_nettype none
// ============================================================================
// dram_reftmr
//   Free-running refresh interval counter with a saturating pending flag.
// Revision: 1.0  initial release
// ============================================================================
module dram_reftmr #(
  parameter int REF_PERIOD = 64
) (
  input  wire  CLK,
  input  wire  RESETL,
  input  wire  CLR,
  output logic PEND
);
  localparam int            CW     = $clog2(REF_PERIOD);
  localparam logic [CW-1:0] c_LAST = CW'(REF_PERIOD - 1);

  logic [CW-1:0] cnt_q;
  logic          pend_q;

  // Count every cycle; an expiry wins over a same-cycle clear so it is never lost.
  always_ff @(posedge CLK or negedge RESETL) begin
    if (!RESETL) begin
      cnt_q  <= '0;
      pend_q <= 1'b0;
    end else if (cnt_q == c_LAST) begin
      cnt_q  <= '0;
      pend_q <= 1'b1;
    end else begin
      cnt_q <= cnt_q + 1'b1;
      if (CLR) begin
        pend_q <= 1'b0;
      end
    end
  end

  assign PEND = pend_q;
endmodule
`default_nettype wire

// File: rtl/dram_seq.sv
`default_nettype none
// ============================================================================
// dram_seq
//   Single-bank DRAM access sequencer: RAS/CAS access cycles with registered
//   strobes, plus CAS-before-RAS refresh that takes priority at IDLE.
// Revision: 1.0  initial release
// ============================================================================
module dram_seq
  import slip_dram_pkg::*;
#(
  parameter int REF_PERIOD = 64,
  parameter int AW         = c_AW_DEFAULT
) (
  input wire        CLK,
  input wire        RESETL,
  dram_seq_if.slave bus
);
  state_e        state_q;
  logic [AW-1:0] row_q;
  logic [AW-1:0] col_q;
  logic          wr_q;
  logic [AW-1:0] ma_q;
  logic          muxsel_q;
  logic          rasl_q;
  logic          casl_q;
  logic          wel_q;
  logic          ack_q;
  logic          busy_q;
  logic          ref_pend;
  logic          ref_clr;

  // Pending is consumed on the IDLE -> RF_CAS transition.
  assign ref_clr = (state_q == ST_IDLE) && ref_pend;

  dram_reftmr #(
    .REF_PERIOD (REF_PERIOD)
  ) u_reftmr (
    .CLK    (CLK),
    .RESETL (RESETL),
    .CLR    (ref_clr),
    .PEND   (ref_pend)
  );

  // Sequencer FSM; every strobe is registered alongside the state it belongs to.
  always_ff @(posedge CLK or negedge RESETL) begin
    if (!RESETL) begin
      state_q  <= ST_IDLE;
      row_q    <= '0;
      col_q    <= '0;
      wr_q     <= 1'b0;
      ma_q     <= '0;
      muxsel_q <= 1'b0;
      rasl_q   <= c_STROBE_OFF;
      casl_q   <= c_STROBE_OFF;
      wel_q    <= c_STROBE_OFF;
      ack_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (ref_pend) begin
            state_q  <= ST_RF_CAS;
            casl_q   <= 1'b0;
            muxsel_q <= 1'b0;
            busy_q   <= 1'b1;
          end else if (bus.REQ) begin
            row_q    <= bus.ADDR[2*AW-1:AW];
            col_q    <= bus.ADDR[AW-1:0];
            wr_q     <= bus.WR;
            ma_q     <= bus.ADDR[2*AW-1:AW];
            muxsel_q <= 1'b0;
            rasl_q   <= 1'b0;
            busy_q   <= 1'b1;
            state_q  <= ST_ROW;
          end
        end
        ST_ROW: begin
          ma_q     <= col_q;
          muxsel_q <= 1'b1;
          state_q  <= ST_COL;
        end
        ST_COL: begin
          casl_q  <= 1'b0;
          wel_q   <= ~wr_q;
          state_q <= ST_CAS1;
        end
        ST_CAS1: begin
          ack_q   <= 1'b1;
          state_q <= ST_CAS2;
        end
        ST_CAS2: begin
          rasl_q   <= c_STROBE_OFF;
          casl_q   <= c_STROBE_OFF;
          wel_q    <= c_STROBE_OFF;
          muxsel_q <= 1'b0;
          ma_q     <= row_q;
          state_q  <= ST_PRE;
        end
        ST_PRE: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        ST_RF_CAS: begin
          rasl_q  <= 1'b0;
          state_q <= ST_RF_RAS;
        end
        ST_RF_RAS: begin
          state_q <= ST_RF_HOLD;
        end
        ST_RF_HOLD: begin
          rasl_q  <= c_STROBE_OFF;
          casl_q  <= c_STROBE_OFF;
          state_q <= ST_PRE;
        end
        default: begin
          rasl_q   <= c_STROBE_OFF;
          casl_q   <= c_STROBE_OFF;
          wel_q    <= c_STROBE_OFF;
          muxsel_q <= 1'b0;
          busy_q   <= 1'b0;
          state_q  <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.MA     = ma_q;
  assign bus.MUXSEL = muxsel_q;
  assign bus.RASL   = rasl_q;
  assign bus.CASL   = casl_q;
  assign bus.WEL    = wel_q;
  assign bus.ACK    = ack_q;
  assign bus.BUSY   = busy_q;
endmodule
`default_nettype wire

// File: tb/tb_dram_seq.sv
`default_nettype none
// ============================================================================
// tb_dram_seq
//   Directed bench for dram_seq: instance A (REF_PERIOD=64) carries the
//   access/refresh/reset sequence, instance B (REF_PERIOD=8) runs saturated
//   back-to-back traffic. Access results go through an expected-value queue.
// Revision: 1.0  initial release
// ============================================================================
module tb_dram_seq;
  localparam int AW = 9;

  typedef struct packed {
    logic [AW-1:0] row;
    logic [AW-1:0] col;
    logic          wr;
  } acc_t;

  logic clk;
  logic rstn_a;
  logic rstn_b;

  dram_seq_if #(.AW(AW)) ifa ();
  dram_seq_if #(.AW(AW)) ifb ();

  dram_seq #(.REF_PERIOD(64), .AW(AW)) u_dut_a (.CLK(clk), .RESETL(rstn_a), .bus(ifa));
  dram_seq #(.REF_PERIOD(8),  .AW(AW)) u_dut_b (.CLK(clk), .RESETL(rstn_b), .bus(ifb));

  int            checks;
  int            errors;
  int            ncyc;
  acc_t          sbq[$];
  logic [AW-1:0] mon_row;
  logic [AW-1:0] mon_col;
  logic          prev_rasl;
  logic          prev_mux;
  logic [5:0]    wr_exp [0:5];
  int            nlow;
  int            nt;
  int            nb;
  int            outst;
  int            age;
  int            nref;
  int            nack;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk6(input string tag, input logic [5:0] obs, input logic [5:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed {RASL,CASL,WEL,MUXSEL,ACK,BUSY}=%b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk9(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] bus_a();
    return {ifa.RASL, ifa.CASL, ifa.WEL, ifa.MUXSEL, ifa.ACK, ifa.BUSY};
  endfunction

  task automatic push_exp(input logic [AW-1:0] row, input logic [AW-1:0] col, input logic wr);
    acc_t e;
    e.row = row;
    e.col = col;
    e.wr  = wr;
    sbq.push_back(e);
  endtask

  // Scoreboard monitor for instance A: capture row/column addresses, compare at ACK.
  task automatic mon_a();
    acc_t e;
    logic exp_wel;
    if (!ifa.RASL && prev_rasl && ifa.CASL) mon_row = ifa.MA;
    if (ifa.MUXSEL && !prev_mux) mon_col = ifa.MA;
    if (ifa.ACK) begin
      if (sbq.size() == 0) begin
        chk1("ack_without_request", ifa.ACK, 1'b0);
      end else begin
        e       = sbq.pop_front();
        exp_wel = ~e.wr;
        chk9("sb.row", mon_row, e.row);
        chk9("sb.col", mon_col, e.col);
        chk1("sb.wel_at_ack", ifa.WEL, exp_wel);
      end
    end
    prev_rasl = ifa.RASL;
    prev_mux  = ifa.MUXSEL;
  endtask

  task automatic tick_a();
    @(posedge clk);
    ncyc++;
    @(negedge clk);
    mon_a();
  endtask

  initial begin
    checks = 0; errors = 0; ncyc = 0;
    prev_rasl = 1'b1; prev_mux = 1'b0;
    mon_row = '0; mon_col = '0;
    rstn_a = 1'b0; rstn_b = 1'b0;
    ifa.REQ = 1'b0; ifa.WR = 1'b0; ifa.ADDR = '0;
    ifb.REQ = 1'b0; ifb.WR = 1'b0; ifb.ADDR = '0;
    wr_exp[0] = 6'b011001;  // ROW
    wr_exp[1] = 6'b011101;  // COL
    wr_exp[2] = 6'b000101;  // CAS1, write
    wr_exp[3] = 6'b000111;  // CAS2, write, ACK
    wr_exp[4] = 6'b111001;  // PRE
    wr_exp[5] = 6'b111000;  // IDLE

    // Reset state
    repeat (3) @(negedge clk);
    chk6("reset.strobes", bus_a(), 6'b111000);
    chk9("reset.MA", ifa.MA, 9'h000);
    rstn_a = 1'b1;
    ncyc   = 0;
    tick_a();

    // Read: row 0x091, column 0x145
    ifa.ADDR = 18'h12345; ifa.WR = 1'b0; ifa.REQ = 1'b1;
    push_exp(9'h091, 9'h145, 1'b0);
    tick_a(); chk6("rd.ROW", bus_a(), 6'b011001); chk9("rd.ROW.MA", ifa.MA, 9'h091);
    tick_a(); chk6("rd.COL", bus_a(), 6'b011101); chk9("rd.COL.MA", ifa.MA, 9'h145);
    tick_a(); chk6("rd.CAS1", bus_a(), 6'b001101);
    tick_a(); chk6("rd.CAS2", bus_a(), 6'b001111);
    ifa.REQ = 1'b0;
    tick_a(); chk6("rd.PRE", bus_a(), 6'b111001);
    tick_a(); chk6("rd.IDLE", bus_a(), 6'b111000);

    // Write: row 0x1FF, column 0x001; WEL low only in CAS1/CAS2
    ifa.ADDR = 18'h3FE01; ifa.WR = 1'b1; ifa.REQ = 1'b1;
    push_exp(9'h1FF, 9'h001, 1'b1);
    nlow = 0;
    for (int i = 0; i < 6; i++) begin
      tick_a();
      chk6($sformatf("wr.step%0d", i), bus_a(), wr_exp[i]);
      if (!ifa.RASL) nlow++;
      if (i == 3) ifa.REQ = 1'b0;
    end
    chki("wr.rasl_low_cycles", nlow, 4);

    // Back-to-back: REQ held across ACK, next address presented after ACK
    ifa.ADDR = 18'h2AAAA; ifa.WR = 1'b0; ifa.REQ = 1'b1;
    push_exp(9'h155, 9'h0AA, 1'b0);
    repeat (4) tick_a();
    chk1("b2b.first_ack", ifa.ACK, 1'b1);
    ifa.ADDR = 18'h15555;
    push_exp(9'h0AA, 9'h155, 1'b0);
    tick_a(); chk6("b2b.PRE", bus_a(), 6'b111001);
    tick_a(); chk6("b2b.IDLE", bus_a(), 6'b111000);
    tick_a(); chk6("b2b.ROW", bus_a(), 6'b011001); chk9("b2b.ROW.MA", ifa.MA, 9'h0AA);
    repeat (3) tick_a();
    chk1("b2b.second_ack", ifa.ACK, 1'b1);
    ifa.REQ = 1'b0;

    // Refresh vs request: REQ rises in the cycle pending sets (edge 64)
    while (ncyc < 64) tick_a();
    chk6("ref.idle_at_expiry", bus_a(), 6'b111000);
    ifa.ADDR = 18'h01234; ifa.WR = 1'b1; ifa.REQ = 1'b1;
    push_exp(9'h009, 9'h034, 1'b1);
    nt = 0;
    tick_a(); nt++; chk6("ref.RF_CAS", bus_a(), 6'b101001);
    tick_a(); nt++; chk6("ref.RF_RAS", bus_a(), 6'b001001);
    tick_a(); nt++; chk6("ref.RF_HOLD", bus_a(), 6'b001001);
    tick_a(); nt++; chk6("ref.PRE", bus_a(), 6'b111001);
    while (!ifa.ACK && nt < 20) begin
      tick_a(); nt++;
    end
    chki("ref.ack_latency", nt, 9);
    ifa.REQ = 1'b0;

    // Reset asserted during CAS1 of a write
    while (ncyc < 80) tick_a();
    ifa.ADDR = 18'h0F0F0; ifa.WR = 1'b1; ifa.REQ = 1'b1;
    repeat (3) tick_a();
    chk6("rst.CAS1", bus_a(), 6'b000101);
    #2;
    rstn_a = 1'b0;
    #1;
    chk6("rst.async_strobes", bus_a(), 6'b111000);
    chk9("rst.async_MA", ifa.MA, 9'h000);
    ifa.REQ = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk1("rst.no_ack", ifa.ACK, 1'b0);
    end
    rstn_a    = 1'b1;
    ncyc      = 0;
    prev_rasl = 1'b1;
    prev_mux  = 1'b0;
    do tick_a(); while (ifa.CASL && ncyc < 100);
    chki("rst.first_refresh_cycle", ncyc, 65);
    chk6("rst.first_refresh_RF_CAS", bus_a(), 6'b101001);
    repeat (5) tick_a();

    // Instance B: REF_PERIOD=8 under continuous requests
    rstn_b = 1'b1;
    ifb.REQ = 1'b1;
    nb = 0; outst = 0; age = 0; nref = 0; nack = 0;
    for (int i = 0; i < 120; i++) begin
      @(posedge clk);
      nb++;
      @(negedge clk);
      if (!ifb.CASL && ifb.RASL) begin
        chki("b.refresh_has_pending", outst, 1);
        outst = 0;
        nref++;
      end
      if (nb % 8 == 0) begin
        chki("b.pending_not_saturated", outst, 0);
        outst = 1;
        age   = 0;
      end else if (outst == 1) begin
        age++;
        chk1("b.refresh_wait_bounded", age <= 7, 1'b1);
      end
      if (ifb.ACK) nack++;
    end
    chki("b.expiries_accounted", nref + outst, 15);
    chk1("b.accesses_progress", nack >= 6, 1'b1);

    chki("sb.drained", sbq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/dram_seq.md
DRAM_SEQ -- requirements
Module: dram_seq

Interface
REQ-001 SHALL have parameter REF_PERIOD, default 64, meaning clock cycles between refresh requests (range 8..127).
REQ-002 SHALL have parameter AW, default 9, meaning row and column address width.
REQ-003 SHALL have port CLK, input, 1, the single system clock; all state changes on its rising edge.
REQ-004 SHALL have port RESETL, input, 1, reset; asynchronous, active-low.
REQ-005 SHALL have port REQ, input, 1, access request; level, held until ACK.
REQ-006 SHALL have port WR, input, 1, write (1) or read (0); sampled with REQ.
REQ-007 SHALL have port ADDR, input, 2*AW, access address; upper AW bits = row, lower AW bits = column.
REQ-008 SHALL have port MA, output, AW, muxed DRAM address; row when MUXSEL=0, column when MUXSEL=1.
REQ-009 SHALL have port MUXSEL, output, 1, row/column select; drives the downstream address mux SEL.
REQ-010 SHALL have ports RASL, CASL and WEL, output, 1 each, active-low DRAM strobes.
REQ-011 SHALL have port ACK, output, 1, one-cycle pulse marking access completion; read data is valid in this cycle.
REQ-012 SHALL have port BUSY, output, 1, high in every state except IDLE.

Function
REQ-013 SHALL implement states IDLE, ROW, COL, CAS1, CAS2, PRE, RF_CAS, RF_RAS, RF_HOLD; all outputs registered.
REQ-014 SHALL, in IDLE with REQ=1 and no pending refresh: latch ADDR and WR, then go to ROW.
REQ-015 SHALL make ROW drive RASL=0, MUXSEL=0, MA=latched row.
REQ-016 SHALL make COL keep RASL=0, set MUXSEL=1 and MA=latched column.
REQ-017 SHALL make CAS1 and CAS2 drive CASL=0 and WEL=~WR.
REQ-018 SHALL pulse ACK=1 during CAS2 only.
REQ-019 SHALL make PRE drive RASL=CASL=WEL=1 and MUXSEL=0, then go to IDLE.
REQ-020 SHALL, at the access timing above, reach the cycle after REQ sampled ROW, COL, CAS1, CAS2 (ACK) in 4 cycles; total access 5 cycles plus 1 IDLE.
REQ-021 SHALL run a free-running refresh counter that sets refresh-pending when it reaches REF_PERIOD-1 and wraps to 0.
REQ-022 SHALL let pending refresh saturate: a second expiry while pending is not counted.
REQ-023 SHALL give refresh priority over REQ in IDLE; a request that arrives with refresh pending waits until refresh ends.
REQ-024 SHALL never abort an access in progress for refresh; refresh starts at the next IDLE.
REQ-025 SHALL run refresh as CAS-before-RAS: RF_CAS (CASL=0), RF_RAS (CASL=0, RASL=0), RF_HOLD (same), PRE.
REQ-026 SHALL clear refresh-pending on entry to RF_CAS.
REQ-027 SHALL keep WEL=1 during refresh.
REQ-028 SHALL go IDLE to ROW directly when REQ is held across ACK (back-to-back); it SHALL NOT re-sample in CAS2 or PRE.
REQ-029 SHALL ignore REQ dropping mid-access; the cycle completes and ACK still pulses.

Reset
REQ-030 SHALL, while RESETL=0, force state IDLE, RASL=CASL=WEL=1, MUXSEL=0, MA=0, ACK=0, BUSY=0.
REQ-031 SHALL, while RESETL=0, clear the refresh counter and refresh-pending.
REQ-032 SHALL, when reset is asserted mid-access, drop strobes asynchronously with no ACK.

Structure
REQ-033 SHALL place the state enum, the AW default, and the strobe-inactive constants in shared package slip_dram_pkg.
REQ-034 SHALL implement the refresh counter and pending flag as a sub-module dram_reftmr (ports CLK, RESETL, CLR, PEND).

Verification
REQ-035 SHALL cover read: REQ=1, WR=0, ADDR=0x1_2345 (row 0x091, col 0x145) -> MA 0x091 in ROW, 0x145 in COL; ACK exactly 4 cycles after sample; WEL=1 throughout.
REQ-036 SHALL cover write: WR=1 -> WEL=0 in CAS1 and CAS2 only; RASL low exactly 4 cycles.
REQ-037 SHALL cover refresh versus request: REQ rises in the same cycle pending sets -> RF_CAS first, CASL falls one cycle before RASL, then access ACK 9 cycles after REQ.
REQ-038 SHALL cover long access blocking: REF_PERIOD=8 with continuous back-to-back REQ -> one refresh between accesses; pending never lost; no second refresh queued.
REQ-039 SHALL cover reset mid-access: RESETL=0 during CAS1 -> RASL, CASL and WEL go high without a clock edge; ACK never pulses; after release, first refresh after 64 cycles.
